// File: rtl/dcache1_puke_gen.sv
// Invalidation dispatcher for the six-lane tag-array valid-clear port: coalescing request FIFO,
// up to six issues per cycle, and a full 128-set flush sweep.
module dcache1_puke_gen #(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst,
   input  logic                     inv_valid_i,
   input  logic [6:0]               inv_addr_i,
   output logic                     inv_ready_o,
   input  logic                     flush_req_i,
   input  logic                     stall_i,
   output logic [5:0]               puke_en_o,
   output logic [41:0]              puke_addr_o,
   output logic                     flush_busy_o,
   output logic                     flush_done_o,
   output logic [$clog2(DEPTH):0]   q_count_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {StIdle, StDrain, StSweep, StDone} state_e;

   state_e        state_q, state_d;
   logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
   logic [7:0]    sc_q, sc_d;
   logic [5:0]    en_q, en_d;
   logic [41:0]   addr_q, addr_d;
   logic          done_q, done_d;
   logic          busy_q;
   logic [6:0]    mem_q [DEPTH];

   logic [AW:0]      count;
   logic [DEPTH-1:0] occ;
   logic             hit;
   logic             push;
   logic [2:0]       n_issue;
   logic [6:0]       rd_lane [6];
   logic [7:0]       sw_lane [6];
   logic [7:0]       sc_next;

   assign count       = wr_q - rd_q;
   assign inv_ready_o = ~rst & (state_q == StIdle) & (count != (AW+1)'(DEPTH));
   assign push        = inv_valid_i & inv_ready_o & ~hit;
   assign n_issue     = (count > (AW+1)'(6)) ? 3'd6 : 3'(count);
   assign sc_next     = sc_q + 8'd6;

   // Entry i is occupied when its distance from the read pointer is below the occupancy.
   always_comb begin
      occ = '0;
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         occ[i] = ({1'b0, AW'(i) - rd_q[AW-1:0]} < count);
         if (occ[i] && (mem_q[i] == inv_addr_i)) hit = 1'b1;
      end
   end

   always_comb begin
      for (int k = 0; k < 6; k++) begin
         rd_lane[k] = mem_q[rd_q[AW-1:0] + AW'(k)];
         sw_lane[k] = sc_q + 8'(k);
      end
   end

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      sc_d    = sc_q;
      en_d    = '0;
      addr_d  = addr_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle, StDrain: begin
            if (!stall_i) begin
               for (int k = 0; k < 6; k++) begin
                  if (3'(k) < n_issue) begin
                     addr_d[7*k +: 7] = rd_lane[k];
                     en_d[k]          = 1'b1;
                  end
               end
               rd_d = rd_q + (AW+1)'(n_issue);
            end
            if (state_q == StIdle) begin
               if (flush_req_i) state_d = StDrain;
            end else if (count == '0) begin
               state_d = StSweep;
               sc_d    = 8'd0;
            end
         end
         StSweep: begin
            if (!stall_i) begin
               for (int k = 0; k < 6; k++) begin
                  if (sw_lane[k] <= 8'd127) begin
                     addr_d[7*k +: 7] = sw_lane[k][6:0];
                     en_d[k]          = 1'b1;
                  end
               end
               sc_d = sc_next;
               if (sc_next > 8'd127) begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (push) wr_d = wr_q + 1'b1;
   end

   always_ff @(negedge clk_i) begin
      if (rst) begin
         state_q <= StIdle;
         wr_q    <= '0;
         rd_q    <= '0;
         sc_q    <= '0;
         en_q    <= '0;
         addr_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         sc_q    <= sc_d;
         en_q    <= en_d;
         addr_q  <= addr_d;
         done_q  <= done_d;
         busy_q  <= (state_d != StIdle);
      end
   end

   // Storage needs no reset: occupancy masks stale entries.
   always_ff @(negedge clk_i) begin
      if (push) mem_q[wr_q[AW-1:0]] <= inv_addr_i;
   end

   assign puke_en_o    = en_q;
   assign puke_addr_o  = addr_q;
   assign flush_busy_o = busy_q;
   assign flush_done_o = done_q;
   assign q_count_o    = count;

endmodule

// File: tb/tb_dcache1_puke_gen.sv
// Randomized and directed bench for dcache1_puke_gen against a queue-based reference model.
module tb_dcache1_puke_gen;

   localparam int DEPTH = 8;
   localparam int M_IDLE = 0, M_DRAIN = 1, M_SWEEP = 2, M_DONE = 3;

   logic        clk = 1'b0;
   logic        rst, inv_valid, flush_req, stall;
   logic [6:0]  inv_addr;
   logic        inv_ready, flush_busy, flush_done;
   logic [5:0]  puke_en;
   logic [41:0] puke_addr;
   logic [3:0]  q_count;

   always #5 clk = ~clk;

   dcache1_puke_gen #(.DEPTH(DEPTH)) u_dut (
      .clk_i        (clk),
      .rst          (rst),
      .inv_valid_i  (inv_valid),
      .inv_addr_i   (inv_addr),
      .inv_ready_o  (inv_ready),
      .flush_req_i  (flush_req),
      .stall_i      (stall),
      .puke_en_o    (puke_en),
      .puke_addr_o  (puke_addr),
      .flush_busy_o (flush_busy),
      .flush_done_o (flush_done),
      .q_count_o    (q_count)
   );

   int checks = 0;
   int errors = 0;

   logic [6:0]  mq [$];
   int          mmode = M_IDLE;
   int          msc = 0;
   logic [5:0]  men = '0;
   logic [41:0] maddr = '0;
   logic        mdone = 1'b0;
   int          seen [128];
   int          done_seen = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // One active edge: drive, check ready, advance model, check registered outputs.
   task automatic step(input logic v, input logic [6:0] a, input logic fr, input logic st,
                       input logic r);
      int  sz, n, nmode, cnt;
      bit  dup, acc, sweeping;
      rst = r; inv_valid = v; inv_addr = a; flush_req = fr; stall = st;
      #1;
      sz  = mq.size();
      dup = 0;
      foreach (mq[i]) if (mq[i] == a) dup = 1;
      acc = v && !r && (mmode == M_IDLE) && (sz != DEPTH);
      chk("inv_ready", 64'(inv_ready), 64'(acc || (!v && !r && mmode == M_IDLE && sz != DEPTH)));
      nmode    = mmode;
      mdone    = 0;
      men      = '0;
      sweeping = 0;
      if (r) begin
         mq.delete();
         nmode = M_IDLE;
         maddr = '0;
         msc   = 0;
      end else begin
         case (mmode)
            M_IDLE, M_DRAIN: begin
               if (!st) begin
                  n = (sz < 6) ? sz : 6;
                  for (int k = 0; k < n; k++) begin
                     maddr[7*k +: 7] = mq.pop_front();
                     men[k] = 1'b1;
                  end
               end
               if (mmode == M_IDLE && fr) nmode = M_DRAIN;
               else if (mmode == M_DRAIN && sz == 0) begin
                  nmode = M_SWEEP;
                  msc   = 0;
                  for (int s = 0; s < 128; s++) seen[s] = 0;
               end
            end
            M_SWEEP: begin
               if (!st) begin
                  sweeping = 1;
                  for (int k = 0; k < 6; k++) begin
                     if (msc + k <= 127) begin
                        maddr[7*k +: 7] = 7'(msc + k);
                        men[k] = 1'b1;
                     end
                  end
                  msc += 6;
                  if (msc > 127) begin
                     nmode = M_DONE;
                     mdone = 1;
                  end
               end
            end
            default: nmode = M_IDLE;
         endcase
         if (acc && !dup) mq.push_back(a);
      end
      mmode = nmode;
      @(negedge clk);
      #1;
      chk("puke_en", 64'(puke_en), 64'(men));
      chk("puke_addr", 64'(puke_addr), 64'(maddr));
      chk("q_count", 64'(q_count), 64'(mq.size()));
      chk("flush_busy", 64'(flush_busy), 64'(mmode != M_IDLE));
      chk("flush_done", 64'(flush_done), 64'(mdone));
      if (flush_done) done_seen++;
      if (sweeping) begin
         for (int k = 0; k < 6; k++)
            if (puke_en[k]) seen[puke_addr[7*k +: 7]]++;
      end
      if (mdone) begin
         cnt = 0;
         for (int s = 0; s < 128; s++) if (seen[s] == 1) cnt++;
         chk("sweep_cover", 64'(cnt), 64'd128);
      end
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0, 7'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic finish_flush();
      for (int i = 0; i < 40 && mmode != M_IDLE; i++) step(1'b0, 7'h0, 1'b0, 1'b0, 1'b0);
      chk("flush_ended", 64'(flush_busy), 64'd0);
   endtask

   initial begin
      int d0;
      rst = 1'b1; inv_valid = 1'b0; inv_addr = '0; flush_req = 1'b0; stall = 1'b0;
      @(negedge clk);
      #1;
      step(1'b0, 7'h0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 7'h33, 1'b1, 1'b0, 1'b1);
      chk("rst_en", 64'(puke_en), 64'd0);

      // Single request latency
      step(1'b1, 7'h45, 1'b0, 1'b0, 1'b0);
      step(1'b0, 7'h0, 1'b0, 1'b0, 1'b0);
      chk("single_en", 64'(puke_en), 64'h1);
      chk("single_lane0", 64'(puke_addr[6:0]), 64'h45);
      step(1'b0, 7'h0, 1'b0, 1'b0, 1'b0);
      chk("single_en_off", 64'(puke_en), 64'h0);

      // Fill under stall, then two issue cycles
      for (int i = 0; i < 8; i++) step(1'b1, 7'(8'h10 + i), 1'b0, 1'b1, 1'b0);
      chk("full_count", 64'(q_count), 64'd8);
      step(1'b1, 7'h20, 1'b0, 1'b1, 1'b0);
      step(1'b0, 7'h0, 1'b0, 1'b0, 1'b0);
      chk("burst1_en", 64'(puke_en), 64'h3f);
      step(1'b0, 7'h0, 1'b0, 1'b0, 1'b0);
      chk("burst2_en", 64'(puke_en), 64'h03);
      chk("burst2_lanes", 64'(puke_addr[13:0]), 64'({7'h17, 7'h16}));

      // Coalescing
      step(1'b1, 7'h12, 1'b0, 1'b1, 1'b0);
      step(1'b1, 7'h12, 1'b0, 1'b1, 1'b0);
      chk("coal_count", 64'(q_count), 64'd1);
      idle(2);

      // Flush with three queued entries
      for (int i = 0; i < 3; i++) step(1'b1, 7'(8'h50 + i), 1'b0, 1'b1, 1'b0);
      d0 = done_seen;
      step(1'b0, 7'h0, 1'b1, 1'b1, 1'b0);
      step(1'b1, 7'h60, 1'b0, 1'b1, 1'b0);
      step(1'b1, 7'h61, 1'b0, 1'b0, 1'b0);
      finish_flush();
      chk("flush_done_pulses", 64'(done_seen - d0), 64'd1);

      // Stall mid-sweep at sc=60
      step(1'b0, 7'h0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 11; i++) step(1'b0, 7'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 7'h0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 7'h0, 1'b0, 1'b0, 1'b0);
      chk("sc60_lanes", 64'(puke_addr),
          64'({7'd65, 7'd64, 7'd63, 7'd62, 7'd61, 7'd60}));
      finish_flush();

      // Reset during sweep
      d0 = done_seen;
      step(1'b0, 7'h0, 1'b1, 1'b0, 1'b0);
      idle(6);
      step(1'b0, 7'h0, 1'b0, 1'b0, 1'b1);
      chk("rst_sweep_busy", 64'(flush_busy), 64'd0);
      idle(25);
      chk("rst_no_done", 64'(done_seen - d0), 64'd0);
      step(1'b1, 7'h33, 1'b0, 1'b0, 1'b0);
      step(1'b0, 7'h0, 1'b0, 1'b0, 1'b0);
      chk("post_rst_en", 64'(puke_en), 64'h1);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [6:0] a;
         a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 11));
         step(1'($urandom_range(0, 2) != 0), a, 1'($urandom_range(0, 59) == 0),
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 399) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
